// File: rtl/io_sw_debounce_if.sv
// LSU-facing register port of the switch peripheral: strobes, word select, write data and read data.
// The LSU drives the master side and the peripheral sits on the slave side.
interface io_sw_debounce_if;
    logic        rd_en_i;
    logic        wr_en_i;
    logic [1:0]  addr_i;
    logic [31:0] wr_data_i;
    logic [31:0] rd_data_o;

    modport master (
        output rd_en_i,
        output wr_en_i,
        output addr_i,
        output wr_data_i,
        input  rd_data_o
    );

    modport slave (
        input  rd_en_i,
        input  wr_en_i,
        input  addr_i,
        input  wr_data_i,
        output rd_data_o
    );
endinterface

// File: rtl/io_sw_debounce.sv
// Board switch conditioner: 2-FF synchroniser, per-bit debounce, sticky rise/fall capture,
// clear-on-read edge registers, writable interrupt mask and a registered masked IRQ.
module io_sw_debounce #(
    parameter int unsigned NUM_SW    = 18,
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_SW-1:0] sw_raw_i,
    io_sw_debounce_if.slave   bus,
    output logic [31:0]       sw_o,
    output logic              irq_o
);
    localparam int unsigned CW = $clog2(DB_CYCLES);

    localparam logic [1:0] ADDR_STATE = 2'd0;
    localparam logic [1:0] ADDR_RISE  = 2'd1;
    localparam logic [1:0] ADDR_FALL  = 2'd2;
    localparam logic [1:0] ADDR_MASK  = 2'd3;

    logic [NUM_SW-1:0] sync1_q, sync_q;
    logic [NUM_SW-1:0] stable_q, stable_d;
    logic [CW-1:0]     cnt_q [NUM_SW];
    logic [CW-1:0]     cnt_d [NUM_SW];
    logic [NUM_SW-1:0] rise_q, rise_d;
    logic [NUM_SW-1:0] fall_q, fall_d;
    logic [NUM_SW-1:0] mask_q, mask_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              irq_q, irq_d;

    logic [NUM_SW-1:0] rise_set, fall_set;
    logic              rd_rise, rd_fall, wr_mask;
    logic [31:0]       unused_wr_data;

    // Upper write-data bits beyond NUM_SW are deliberately ignored.
    assign unused_wr_data = bus.wr_data_i;

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(NUM_SW); i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CW'(DB_CYCLES - 1)) stable_d[i] = sync_q[i];
                else                                cnt_d[i]    = cnt_q[i] + CW'(1);
            end
        end

        rise_set = stable_d & ~stable_q;
        fall_set = ~stable_d & stable_q;
        rd_rise  = bus.rd_en_i && (bus.addr_i == ADDR_RISE);
        rd_fall  = bus.rd_en_i && (bus.addr_i == ADDR_FALL);
        wr_mask  = bus.wr_en_i && (bus.addr_i == ADDR_MASK);

        // Clear-on-read happens first so an edge landing on the same cycle survives.
        rise_d = (rd_rise ? '0 : rise_q) | rise_set;
        fall_d = (rd_fall ? '0 : fall_q) | fall_set;
        mask_d = wr_mask ? bus.wr_data_i[NUM_SW-1:0] : mask_q;

        rd_data_d = rd_data_q;
        if (bus.rd_en_i) begin
            case (bus.addr_i)
                ADDR_STATE: rd_data_d = 32'(stable_q);
                ADDR_RISE:  rd_data_d = 32'(rise_q);
                ADDR_FALL:  rd_data_d = 32'(fall_q);
                default:    rd_data_d = 32'(mask_q);
            endcase
        end

        irq_d = |((rise_d | fall_d) & mask_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= '0;
            sync_q    <= '0;
            stable_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            mask_q    <= '0;
            rd_data_q <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < int'(NUM_SW); i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= sw_raw_i;
            sync_q    <= sync1_q;
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            mask_q    <= mask_d;
            rd_data_q <= rd_data_d;
            irq_q     <= irq_d;
            for (int i = 0; i < int'(NUM_SW); i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign sw_o          = 32'(stable_q);
    assign irq_o         = irq_q;
    assign bus.rd_data_o = rd_data_q;
endmodule
